// File: rtl/vp_recovery_ctrl_if.sv
// Handshake bundle between the value predictor and the recovery responder.
// The predictor side is the master; vp_recovery_ctrl is the slave.
interface vp_recovery_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 32
);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  vp_lock;
  logic                  en_recover;
  logic                  vp_done;
  logic [ADDR_WIDTH-1:0] last_predicted_pc;
  logic                  recovery_done_ack;
  logic                  ckpt_take;
  logic                  flush;
  logic                  stall;
  logic                  rf_restore_en;
  logic [IDX_W-1:0]      rf_restore_base;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  recovery_done;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  recover_count;
  logic [CNT_WIDTH-1:0]  correct_count;

  modport master (
    output vp_lock, en_recover, vp_done, last_predicted_pc, recovery_done_ack,
    input  ckpt_take, flush, stall, rf_restore_en, rf_restore_base, redirect_valid,
           redirect_pc, recovery_done, busy, recover_count, correct_count
  );

  modport slave (
    input  vp_lock, en_recover, vp_done, last_predicted_pc, recovery_done_ack,
    output ckpt_take, flush, stall, rf_restore_en, rf_restore_base, redirect_valid,
           redirect_pc, recovery_done, busy, recover_count, correct_count
  );
endinterface

// File: rtl/vp_recovery_ctrl.sv
// Value-prediction recovery responder: checkpoints the register file, then on a
// misprediction flushes, restores the checkpoint group by group and redirects fetch.
module vp_recovery_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int REGS_PER_CYCLE = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  vp_recovery_ctrl_if.slave bus
);
  localparam int GROUPS  = NUM_REGS / REGS_PER_CYCLE;
  localparam int RC_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int LOG_RPC = $clog2(REGS_PER_CYCLE);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(GROUPS - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, RESTORE, REDIRECT, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  vp_lock_q;
  logic                  armed;
  logic                  start;
  logic [RC_W-1:0]       rc;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [CNT_WIDTH-1:0]  recover_cnt;
  logic [CNT_WIDTH-1:0]  correct_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // armed blocks a level-held en_recover from re-triggering once we are back in IDLE
  assign start = (state == IDLE) & bus.en_recover & bus.vp_lock & armed;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vp_lock_q   <= 1'b0;
      armed       <= 1'b1;
      rc          <= '0;
      recover_cnt <= '0;
      correct_cnt <= '0;
    end else begin
      vp_lock_q <= bus.vp_lock;
      if (start)                armed <= 1'b0;
      else if (!bus.en_recover) armed <= 1'b1;
      if (state == FLUSH)                          rc <= '0;
      else if (state == RESTORE && rc != RC_LAST)  rc <= rc + 1'b1;
      if (state == IDLE && bus.vp_done && !start)  correct_cnt <= sat_inc(correct_cnt);
      if (state == DONE && bus.recovery_done_ack)  recover_cnt <= sat_inc(recover_cnt);
    end
  end

  // captured PC is only ever observed through REDIRECT, so it needs no reset
  always_ff @(posedge clk) begin
    if (start) pc_q <= bus.last_predicted_pc;
  end

  always_comb begin
    state_nxt           = state;
    bus.flush           = 1'b0;
    bus.stall           = 1'b0;
    bus.rf_restore_en   = 1'b0;
    bus.rf_restore_base = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.recovery_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FLUSH;
      end
      FLUSH: begin
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        state_nxt = RESTORE;
      end
      RESTORE: begin
        bus.rf_restore_en   = 1'b1;
        bus.rf_restore_base = IDX_W'(rc) << LOG_RPC;
        bus.stall           = 1'b1;
        if (rc == RC_LAST) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc_q + ADDR_WIDTH'(4);
        bus.stall          = 1'b1;
        state_nxt          = DONE;
      end
      DONE: begin
        bus.recovery_done = 1'b1;
        if (bus.recovery_done_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ckpt_take     = rst_n & bus.vp_lock & ~vp_lock_q & (state == IDLE);
  assign bus.busy          = (state != IDLE);
  assign bus.recover_count = recover_cnt;
  assign bus.correct_count = correct_cnt;
endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// Scoreboard bench for vp_recovery_ctrl: expected output events are queued when
// stimulus is driven and matched as the DUT produces them.
module tb_vp_recovery_ctrl;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   prev_done = 0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t   sb[$];
  string ev_name[6] = '{"ev_ckpt", "ev_flush", "ev_restore", "ev_redirect", "ev_done_rise", "ev_done_fall"};

  vp_recovery_ctrl_if #(.ADDR_WIDTH(32), .NUM_REGS(32), .CNT_WIDTH(32)) bus ();
  vp_recovery_ctrl_if #(.ADDR_WIDTH(32), .NUM_REGS(32), .CNT_WIDTH(4))  b4 ();

  vp_recovery_ctrl #(.ADDR_WIDTH(32), .NUM_REGS(32), .REGS_PER_CYCLE(4), .CNT_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vp_recovery_ctrl #(.ADDR_WIDTH(32), .NUM_REGS(32), .REGS_PER_CYCLE(4), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    sb.push_back(e);
  endtask

  // observed event packed as {kind, cycle, stall, value}
  task automatic match(input int k, input logic [31:0] v);
    ev_t         e;
    logic [63:0] o;
    logic [63:0] x;
    o = {8'(k), 23'(cyc), bus.stall, v};
    if (sb.size() == 0) begin
      chk({"sb_unexpected_", ev_name[k]}, 64'(k) + 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      x = {8'(e.kind), 23'(e.cyc), (e.kind >= 1 && e.kind <= 3), e.val};
      chk(ev_name[k], o, x);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.ckpt_take === 1'b1)      match(0, 32'd0);
      if (bus.flush === 1'b1)          match(1, 32'd0);
      if (bus.rf_restore_en === 1'b1)  match(2, 32'(bus.rf_restore_base));
      if (bus.redirect_valid === 1'b1) match(3, bus.redirect_pc);
      if (bus.recovery_done === 1'b1 && !prev_done) match(4, 32'd0);
      if (bus.recovery_done !== 1'b1 && prev_done)  match(5, 32'd0);
      prev_done = (bus.recovery_done === 1'b1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000ns");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_recovery(input int ack_dly, input bit hold, input int early_ack);
    int t;
    bit seen;
    t = cyc;
    bus.en_recover = 1'b1;
    push(1, t + 1, 32'd0);
    for (int k = 0; k < 8; k++) push(2, t + 2 + k, 32'(4 * k));
    push(3, t + 10, bus.last_predicted_pc + 32'd4);
    push(4, t + 11, 32'd0);
    step(1);
    bus.vp_done = 1'b0;
    if (!hold) bus.en_recover = 1'b0;
    if (early_ack > 0) begin
      step(early_ack - 1);
      bus.recovery_done_ack = 1'b1;
      step(1);
      bus.recovery_done_ack = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.recovery_done === 1'b1) seen = 1;
      else step(1);
    end
    chk("done_timeout", 64'(seen), 64'd1);
    step(ack_dly);
    bus.recovery_done_ack = 1'b1;
    push(5, cyc + 1, 32'd0);
    step(1);
    bus.recovery_done_ack = 1'b0;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    bus.vp_lock = 0; bus.en_recover = 0; bus.vp_done = 0;
    bus.last_predicted_pc = '0; bus.recovery_done_ack = 0;
    b4.vp_lock = 0; b4.en_recover = 0; b4.vp_done = 0;
    b4.last_predicted_pc = '0; b4.recovery_done_ack = 0;
    step(2);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_recover_count", 64'(bus.recover_count), 64'd0);
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 3; i++) begin
      bus.vp_done = 1'b1; step(1);
      bus.vp_done = 1'b0; step(1);
    end
    chk("correct_count_3", 64'(bus.correct_count), 64'd3);

    // speculation window opens, then recover with vp_done in the same cycle
    bus.last_predicted_pc = 32'h0040_0010;
    bus.vp_lock = 1'b1;
    push(0, cyc, 32'd0);
    step(1);
    bus.vp_done = 1'b1;
    do_recovery(2, 1'b0, 0);
    step(1);
    chk("recover_count_1", 64'(bus.recover_count), 64'd1);
    chk("correct_count_hold", 64'(bus.correct_count), 64'd3);
    chk("busy_after_1", 64'(bus.busy), 64'd0);

    // en_recover held past the ack must not retrigger
    do_recovery(2, 1'b1, 0);
    step(5);
    chk("busy_held_en", 64'(bus.busy), 64'd0);
    chk("recover_count_2", 64'(bus.recover_count), 64'd2);
    bus.en_recover = 1'b0;
    step(1);
    do_recovery(2, 1'b0, 0);
    chk("recover_count_3", 64'(bus.recover_count), 64'd3);

    bus.last_predicted_pc = 32'hFFFF_FFFC;
    step(1);
    do_recovery(1, 1'b0, 0);
    chk("recover_count_4", 64'(bus.recover_count), 64'd4);

    bus.vp_lock = 1'b0;
    step(1);
    bus.en_recover = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("busy_nolock", 64'(bus.busy), 64'd0);
    end
    bus.en_recover = 1'b0;
    step(1);

    // early ack during RESTORE is ignored
    bus.last_predicted_pc = 32'h0000_1000;
    bus.vp_lock = 1'b1;
    push(0, cyc, 32'd0);
    step(1);
    do_recovery(1, 1'b0, 3);
    chk("recover_count_5", 64'(bus.recover_count), 64'd5);

    // reset while restoring group 3
    step(1);
    t = cyc;
    bus.en_recover = 1'b1;
    push(1, t + 1, 32'd0);
    for (int k = 0; k < 4; k++) push(2, t + 2 + k, 32'(4 * k));
    step(1);
    bus.en_recover = 1'b0;
    step(4);
    rst_n = 1'b0;
    step(1);
    chk("mid_rst_flush", 64'(bus.flush), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall), 64'd0);
    chk("mid_rst_restore_en", 64'(bus.rf_restore_en), 64'd0);
    chk("mid_rst_restore_base", 64'(bus.rf_restore_base), 64'd0);
    chk("mid_rst_redirect", 64'({bus.redirect_valid, bus.redirect_pc}), 64'd0);
    chk("mid_rst_done", 64'(bus.recovery_done), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_ckpt", 64'(bus.ckpt_take), 64'd0);
    chk("mid_rst_counts", {bus.recover_count, bus.correct_count}, 64'd0);
    rst_n = 1'b1;
    push(0, cyc, 32'd0);
    step(2);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 17; i++) begin
      b4.vp_done = 1'b1; step(1);
      b4.vp_done = 1'b0; step(1);
      if (i == 13) chk("cnt4_14", 64'(b4.correct_count), 64'd14);
    end
    chk("cnt4_saturated", 64'(b4.correct_count), 64'd15);

    step(2);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
